// File: rtl/ext_loader_pkg.sv
// Shared encodings for the external memory loader:
// header layout, op codes, address strides and FSM states.
package ext_loader_pkg;

  localparam logic [3:0] OP_WR_I    = 4'd0;
  localparam logic [3:0] OP_WR_D    = 4'd1;
  localparam logic [3:0] OP_RD_I    = 4'd2;
  localparam logic [3:0] OP_RD_D    = 4'd3;
  localparam logic [3:0] OP_RUN     = 4'd4;
  localparam logic [3:0] OP_HALT    = 4'd5;
  localparam logic [3:0] OP_CLR_ERR = 4'd6;

  localparam int HDR_OP_MSB   = 63;
  localparam int HDR_OP_LSB   = 60;
  localparam int HDR_CNT_LSB  = 48;
  localparam int HDR_BASE_MSB = 31;

  localparam logic [31:0] STRIDE_I = 32'd4;
  localparam logic [31:0] STRIDE_D = 32'd8;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_ISSUE,
    RD_WAIT,
    RD_SEND
  } state_e;

endpackage

// File: rtl/ext_loader_hdr_decode.sv
// Combinational header unpack and op legality check
// for the external memory loader.
module ext_loader_hdr_decode
  import ext_loader_pkg::*;
#(
  parameter int CNT_W = 12
) (
  input  logic [63:0]      hdr_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [31:0]      base_o,
  output logic             wr_o,
  output logic             rd_o,
  output logic             dmem_o,
  output logic             run_o,
  output logic             halt_o,
  output logic             clr_o,
  output logic             ill_o
);

  logic [3:0]  op;
  logic        hdr_unused;

  assign op         = hdr_i[HDR_OP_MSB:HDR_OP_LSB];
  assign cnt_o      = hdr_i[HDR_CNT_LSB +: CNT_W];
  assign base_o     = hdr_i[HDR_BASE_MSB:0];
  assign hdr_unused = ^hdr_i[47:32];

  always_comb begin
    wr_o   = 1'b0;
    rd_o   = 1'b0;
    dmem_o = 1'b0;
    run_o  = 1'b0;
    halt_o = 1'b0;
    clr_o  = 1'b0;
    ill_o  = 1'b0;
    unique case (1'b1)
      (op == OP_WR_I):    wr_o = 1'b1;
      (op == OP_WR_D):    begin wr_o = 1'b1; dmem_o = 1'b1; end
      (op == OP_RD_I):    rd_o = 1'b1;
      (op == OP_RD_D):    begin rd_o = 1'b1; dmem_o = 1'b1; end
      (op == OP_RUN):     run_o = 1'b1;
      (op == OP_HALT):    halt_o = 1'b1;
      (op == OP_CLR_ERR): clr_o = 1'b1;
      default:            ill_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/ext_mem_loader.sv
// Host-side master of the CPU ext memory ports: writes and reads
// IMEM/DMEM from a 64-bit command stream and drives cpu_enable.
module ext_mem_loader
  import ext_loader_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 12
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [63:0] s_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [63:0] m_data,
  output logic [63:0] addr_ext,
  output logic        wen_ext,
  output logic        ren_ext,
  output logic [31:0] wdata_ext,
  input  logic [31:0] rdata_ext,
  output logic [63:0] addr_ext_2,
  output logic        wen_ext_2,
  output logic        ren_ext_2,
  output logic [63:0] wdata_ext_2,
  input  logic [63:0] rdata_ext_2,
  output logic        cpu_enable,
  output logic        busy,
  output logic        err
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic             dmem_q, dmem_d;
  logic             rej_q, rej_d;
  logic [1:0]       lat_q, lat_d;
  logic             cpu_en_q, cpu_en_d;
  logic             err_q, err_d;
  logic             wen_i_q, wen_i_d, ren_i_q, ren_i_d;
  logic             wen_d_q, wen_d_d, ren_d_q, ren_d_d;
  logic [31:0]      ai_q, ai_d, ad_q, ad_d;
  logic [31:0]      wi_q, wi_d;
  logic [63:0]      wd_q, wd_d;
  logic             mv_q, mv_d;
  logic [63:0]      md_q, md_d;

  logic [CNT_W-1:0] h_cnt;
  logic [31:0]      h_base;
  logic             h_wr, h_rd, h_dmem;
  logic             h_run, h_halt, h_clr, h_ill;
  logic             acc;
  logic             iss, iss_live, iss_dmem;
  logic [31:0]      iss_addr, stride;

  ext_loader_hdr_decode #(
    .CNT_W (CNT_W)
  ) u_dec (
    .hdr_i  (s_data),
    .cnt_o  (h_cnt),
    .base_o (h_base),
    .wr_o   (h_wr),
    .rd_o   (h_rd),
    .dmem_o (h_dmem),
    .run_o  (h_run),
    .halt_o (h_halt),
    .clr_o  (h_clr),
    .ill_o  (h_ill)
  );

  assign s_ready = !arst && (state_q == IDLE || state_q == WR);
  assign acc     = s_valid && s_ready;
  assign stride  = dmem_q ? STRIDE_D : STRIDE_I;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    dmem_d   = dmem_q;
    rej_d    = rej_q;
    lat_d    = lat_q;
    cpu_en_d = cpu_en_q;
    err_d    = err_q;
    wen_i_d  = 1'b0;
    wen_d_d  = 1'b0;
    ren_i_d  = 1'b0;
    ren_d_d  = 1'b0;
    ai_d     = ai_q;
    ad_d     = ad_q;
    wi_d     = wi_q;
    wd_d     = wd_q;
    mv_d     = mv_q;
    md_d     = md_q;
    iss      = 1'b0;
    iss_live = 1'b0;
    iss_dmem = dmem_q;
    iss_addr = addr_q;
    unique case (state_q)
      IDLE: begin
        if (acc) begin
          if (h_wr || h_rd) begin
            rej_d  = cpu_en_q;
            err_d  = err_q | cpu_en_q;
            cnt_d  = h_cnt;
            addr_d = h_base;
            dmem_d = h_dmem;
            if (h_wr) begin
              state_d = WR;
            end else begin
              state_d  = RD_ISSUE;
              iss      = 1'b1;
              iss_live = !cpu_en_q;
              iss_dmem = h_dmem;
              iss_addr = h_base;
            end
          end
          if (h_run)  cpu_en_d = 1'b1;
          if (h_halt) cpu_en_d = 1'b0;
          if (h_clr)  err_d = 1'b0;
          if (h_ill)  err_d = 1'b1;
        end
      end
      WR: begin
        if (acc) begin
          if (!rej_q && dmem_q) begin
            wen_d_d = 1'b1;
            ad_d    = addr_q;
            wd_d    = s_data;
          end else if (!rej_q) begin
            wen_i_d = 1'b1;
            ai_d    = addr_q;
            wi_d    = s_data[31:0];
          end
          addr_d = addr_q + stride;
          if (cnt_q == '0) state_d = IDLE;
          else cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RD_ISSUE: begin
        addr_d  = addr_q + stride;
        lat_d   = 2'(RD_LAT - 1);
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (lat_q == 2'd0) begin
          mv_d    = 1'b1;
          state_d = RD_SEND;
          if (rej_q)       md_d = 64'h0;
          else if (dmem_q) md_d = rdata_ext_2;
          else             md_d = {32'h0, rdata_ext};
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end
      RD_SEND: begin
        if (m_ready) begin
          mv_d = 1'b0;
          if (cnt_q == '0) begin
            state_d = IDLE;
          end else begin
            cnt_d    = cnt_q - CNT_W'(1);
            state_d  = RD_ISSUE;
            iss      = 1'b1;
            iss_live = !rej_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Read address and enable are registered so ren lines up with RD_ISSUE
    if (iss && iss_live) begin
      if (iss_dmem) begin
        ren_d_d = 1'b1;
        ad_d    = iss_addr;
      end else begin
        ren_i_d = 1'b1;
        ai_d    = iss_addr;
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      dmem_q   <= 1'b0;
      rej_q    <= 1'b0;
      lat_q    <= '0;
      cpu_en_q <= 1'b0;
      err_q    <= 1'b0;
      wen_i_q  <= 1'b0;
      wen_d_q  <= 1'b0;
      ren_i_q  <= 1'b0;
      ren_d_q  <= 1'b0;
      ai_q     <= '0;
      ad_q     <= '0;
      wi_q     <= '0;
      wd_q     <= '0;
      mv_q     <= 1'b0;
      md_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      dmem_q   <= dmem_d;
      rej_q    <= rej_d;
      lat_q    <= lat_d;
      cpu_en_q <= cpu_en_d;
      err_q    <= err_d;
      wen_i_q  <= wen_i_d;
      wen_d_q  <= wen_d_d;
      ren_i_q  <= ren_i_d;
      ren_d_q  <= ren_d_d;
      ai_q     <= ai_d;
      ad_q     <= ad_d;
      wi_q     <= wi_d;
      wd_q     <= wd_d;
      mv_q     <= mv_d;
      md_q     <= md_d;
    end
  end

  assign addr_ext    = {32'h0, ai_q};
  assign wen_ext     = wen_i_q;
  assign ren_ext     = ren_i_q;
  assign wdata_ext   = wi_q;
  assign addr_ext_2  = {32'h0, ad_q};
  assign wen_ext_2   = wen_d_q;
  assign ren_ext_2   = ren_d_q;
  assign wdata_ext_2 = wd_q;
  assign m_valid     = mv_q;
  assign m_data      = md_q;
  assign cpu_enable  = cpu_en_q;
  assign err         = err_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_ext_mem_loader.sv
// Directed bench for ext_mem_loader with behavioural IMEM/DMEM
// models (read latency 1) and a write/access monitor.
module tb_ext_mem_loader;

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [63:0] s_data = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [63:0] m_data;
  logic [63:0] addr_ext;
  logic        wen_ext, ren_ext;
  logic [31:0] wdata_ext;
  logic [31:0] rdata_ext = '0;
  logic [63:0] addr_ext_2;
  logic        wen_ext_2, ren_ext_2;
  logic [63:0] wdata_ext_2;
  logic [63:0] rdata_ext_2 = '0;
  logic        cpu_enable, busy, err;

  int nvec = 0;
  int nerr = 0;

  ext_mem_loader #(.RD_LAT(1), .CNT_W(12)) dut (
    .clk(clk), .arst(arst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
    .wdata_ext(wdata_ext), .rdata_ext(rdata_ext),
    .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2),
    .ren_ext_2(ren_ext_2), .wdata_ext_2(wdata_ext_2),
    .rdata_ext_2(rdata_ext_2),
    .cpu_enable(cpu_enable), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  logic [31:0] imem [0:255];
  logic [63:0] dmem [0:255];

  initial begin
    for (int i = 0; i < 256; i++) begin
      imem[i] = '0;
      dmem[i] = '0;
    end
  end

  always @(posedge clk) begin
    if (wen_ext) imem[addr_ext[9:2]] <= wdata_ext;
    if (ren_ext) rdata_ext <= imem[addr_ext[9:2]];
    if (wen_ext_2) dmem[addr_ext_2[10:3]] <= wdata_ext_2;
    if (ren_ext_2) rdata_ext_2 <= dmem[addr_ext_2[10:3]];
  end

  int cyc = 0;
  int hs = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (m_valid && m_ready) hs <= hs + 1;
  end

  logic [31:0] wi_a [$];
  logic [31:0] wi_d [$];
  int          wi_c [$];
  logic [31:0] wd_a [$];
  logic [63:0] wd_d [$];
  int ren_i = 0;
  int ren_d = 0;
  int viol = 0;

  always @(negedge clk) begin
    if (wen_ext) begin
      wi_a.push_back(addr_ext[31:0]);
      wi_d.push_back(wdata_ext);
      wi_c.push_back(cyc);
    end
    if (wen_ext_2) begin
      wd_a.push_back(addr_ext_2[31:0]);
      wd_d.push_back(wdata_ext_2);
    end
    if (ren_ext) ren_i++;
    if (ren_ext_2) ren_d++;
    if ((wen_ext && ren_ext) || (wen_ext_2 && ren_ext_2)) viol++;
    if ((wen_ext || ren_ext) && (wen_ext_2 || ren_ext_2)) viol++;
    if (addr_ext[63:32] != 0 || addr_ext_2[63:32] != 0) viol++;
  end

  function automatic logic [63:0] hdr(input logic [3:0] op,
                                      input logic [11:0] cnt,
                                      input logic [31:0] base);
    return {op, cnt, 16'hA5A5, base};
  endfunction

  task automatic send(input logic [63:0] w);
    bit ok;
    ok = 1'b0;
    s_valid = 1'b1;
    s_data = w;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (s_ready) ok = 1'b1;
      @(negedge clk);
    end
    s_valid = 1'b0;
    nvec++;
    if (!ok) begin
      nerr++;
      $display("FAIL send_timeout: word %h never accepted", w);
    end
  endtask

  task automatic recv(output logic [63:0] d);
    bit ok;
    ok = 1'b0;
    d = '0;
    m_ready = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (m_valid) begin
        ok = 1'b1;
        d = m_data;
      end
      @(negedge clk);
    end
    m_ready = 1'b0;
    nvec++;
    if (!ok) begin
      nerr++;
      $display("FAIL recv_timeout: no m_valid within 50 cycles");
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    nvec++;
    if ({m_valid, wen_ext, ren_ext, wen_ext_2, ren_ext_2, cpu_enable, busy, err} !== 8'h0) begin
      nerr++;
      $display("FAIL reset_ctrl: got %b want 0", {m_valid, wen_ext, ren_ext, wen_ext_2, ren_ext_2, cpu_enable, busy, err});
    end
    nvec++;
    if ({addr_ext, addr_ext_2, wdata_ext, wdata_ext_2, m_data} !== '0) begin
      nerr++;
      $display("FAIL reset_data: addr/data outputs not zero");
    end
    arst = 1'b0;
    @(negedge clk);
    nvec++;
    if (s_ready !== 1'b1 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL reset_idle: s_ready=%b busy=%b want 1 0", s_ready, busy);
    end
  endtask

  task automatic test_wr_i;
    logic [31:0] ea [3];
    logic [31:0] ed [3];
    ea = '{32'h10, 32'h14, 32'h18};
    ed = '{32'h13, 32'h00500093, 32'h00A00113};
    wi_a.delete(); wi_d.delete(); wi_c.delete();
    send(hdr(4'd0, 12'd2, 32'h10));
    send({32'hDEAD_BEEF, ed[0]});
    send({32'hCAFE_0001, ed[1]});
    send({32'h1234_5678, ed[2]});
    nvec++;
    if (wen_ext !== 1'b1 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL wr_i_last: wen=%b busy=%b want 1 0", wen_ext, busy);
    end
    repeat (2) @(negedge clk);
    nvec++;
    if (wi_a.size() != 3) begin
      nerr++;
      $display("FAIL wr_i_count: got %0d want 3", wi_a.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        nvec++;
        if (wi_a[i] !== ea[i] || wi_d[i] !== ed[i]) begin
          nerr++;
          $display("FAIL wr_i_word%0d: got %h/%h want %h/%h", i, wi_a[i], wi_d[i], ea[i], ed[i]);
        end
      end
      nvec++;
      if (wi_c[1] - wi_c[0] != 1 || wi_c[2] - wi_c[1] != 1) begin
        nerr++;
        $display("FAIL back_to_back: wen gaps %0d %0d want 1 1", wi_c[1] - wi_c[0], wi_c[2] - wi_c[1]);
      end
    end
    nvec++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL wr_i_after: err=%b busy=%b want 0 0", err, busy);
    end
  endtask

  task automatic test_wr_rd_d;
    logic [63:0] v;
    int h0;
    v = 64'h1122334455667788;
    wd_a.delete(); wd_d.delete();
    send(hdr(4'd1, 12'd0, 32'h8));
    send(v);
    repeat (2) @(negedge clk);
    nvec++;
    if (wd_a.size() != 1 || wd_a[0] !== 32'h8 || wd_d[0] !== v) begin
      nerr++;
      $display("FAIL wr_d: %0d writes, first %h/%h want 1 at 8/%h", wd_a.size(), wd_a[0], wd_d[0], v);
    end
    h0 = hs;
    send(hdr(4'd3, 12'd0, 32'h8));
    nvec++;
    if (ren_ext_2 !== 1'b1 || addr_ext_2 !== 64'h8 || s_ready !== 1'b0) begin
      nerr++;
      $display("FAIL rd_d_issue: ren2=%b addr2=%h s_ready=%b want 1 8 0", ren_ext_2, addr_ext_2, s_ready);
    end
    @(negedge clk);
    nvec++;
    if (m_valid !== 1'b0 || ren_ext_2 !== 1'b0) begin
      nerr++;
      $display("FAIL rd_d_wait: m_valid=%b ren2=%b want 0 0", m_valid, ren_ext_2);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      nvec++;
      if (m_valid !== 1'b1 || m_data !== v) begin
        nerr++;
        $display("FAIL rd_d_hold%0d: m_valid=%b m_data=%h want 1 %h", i, m_valid, m_data, v);
      end
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    nvec++;
    if (m_valid !== 1'b0 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL rd_d_done: m_valid=%b busy=%b want 0 0", m_valid, busy);
    end
    repeat (3) @(negedge clk);
    nvec++;
    if (hs - h0 != 1) begin
      nerr++;
      $display("FAIL rd_d_hs: got %0d handshakes want 1", hs - h0);
    end
  endtask

  task automatic test_run_reject;
    int nw;
    int nr;
    logic [63:0] d;
    send(hdr(4'd4, 12'd0, 32'h0));
    nvec++;
    if (cpu_enable !== 1'b1 || err !== 1'b0) begin
      nerr++;
      $display("FAIL run: cpu_enable=%b err=%b want 1 0", cpu_enable, err);
    end
    nw = wd_a.size();
    send(hdr(4'd1, 12'd1, 32'h40));
    send(64'hFFFF_0000_FFFF_0000);
    send(64'h0123_4567_89AB_CDEF);
    repeat (2) @(negedge clk);
    nvec++;
    if (wd_a.size() != nw || err !== 1'b1 || busy !== 1'b0 || cpu_enable !== 1'b1) begin
      nerr++;
      $display("FAIL rej_wr: writes=%0d err=%b busy=%b en=%b want 0 1 0 1", wd_a.size() - nw, err, busy, cpu_enable);
    end
    nr = ren_i;
    send(hdr(4'd2, 12'd1, 32'h10));
    for (int i = 0; i < 2; i++) begin
      recv(d);
      nvec++;
      if (d !== 64'h0) begin
        nerr++;
        $display("FAIL rej_rd%0d: got %h want 0", i, d);
      end
    end
    @(negedge clk);
    nvec++;
    if (ren_i != nr || busy !== 1'b0) begin
      nerr++;
      $display("FAIL rej_rd_ren: ren pulses %0d busy=%b want 0 0", ren_i - nr, busy);
    end
    send(hdr(4'd6, 12'd0, 32'h0));
    nvec++;
    if (err !== 1'b0 || cpu_enable !== 1'b1) begin
      nerr++;
      $display("FAIL clr_err: err=%b en=%b want 0 1", err, cpu_enable);
    end
    send(hdr(4'd5, 12'd0, 32'h0));
    nvec++;
    if (cpu_enable !== 1'b0) begin
      nerr++;
      $display("FAIL halt: cpu_enable=%b want 0", cpu_enable);
    end
  endtask

  task automatic test_illegal;
    int ni;
    int nd;
    int ri;
    int rd;
    logic [63:0] d;
    ni = wi_a.size(); nd = wd_a.size();
    ri = ren_i; rd = ren_d;
    send(hdr(4'd9, 12'd3, 32'h10));
    nvec++;
    if (err !== 1'b1 || s_ready !== 1'b1 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL illegal: err=%b s_ready=%b busy=%b want 1 1 0", err, s_ready, busy);
    end
    repeat (2) @(negedge clk);
    nvec++;
    if (wi_a.size() != ni || wd_a.size() != nd || ren_i != ri || ren_d != rd) begin
      nerr++;
      $display("FAIL illegal_access: memory touched after illegal op");
    end
    send(hdr(4'd2, 12'd1, 32'h10));
    recv(d);
    nvec++;
    if (d !== 64'h0000_0000_0000_0013) begin
      nerr++;
      $display("FAIL rd_i_w0: got %h want 13", d);
    end
    recv(d);
    nvec++;
    if (d !== 64'h0000_0000_0050_0093) begin
      nerr++;
      $display("FAIL rd_i_w1: got %h want 500093", d);
    end
    @(negedge clk);
    nvec++;
    if (ren_i - ri != 2 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL rd_i_ren: got %0d pulses busy=%b want 2 0", ren_i - ri, busy);
    end
    send(hdr(4'd6, 12'd0, 32'h0));
  endtask

  task automatic test_wrap;
    wi_a.delete(); wi_d.delete(); wi_c.delete();
    send(hdr(4'd0, 12'd1, 32'hFFFF_FFFC));
    send(64'h0000_0000_AAAA_0001);
    send(64'h0000_0000_BBBB_0002);
    repeat (2) @(negedge clk);
    nvec++;
    if (wi_a.size() != 2) begin
      nerr++;
      $display("FAIL wrap_count: got %0d want 2", wi_a.size());
    end else if (wi_a[0] !== 32'hFFFF_FFFC || wi_a[1] !== 32'h0 || wi_d[1] !== 32'hBBBB_0002) begin
      nerr++;
      $display("FAIL wrap_addr: got %h %h want fffffffc 0", wi_a[0], wi_a[1]);
    end
  endtask

  task automatic test_arst;
    logic [63:0] d;
    bit ok;
    send(hdr(4'd4, 12'd0, 32'h0));
    send(hdr(4'd2, 12'd3, 32'h10));
    recv(d);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (m_valid) ok = 1'b1;
      else @(negedge clk);
    end
    nvec++;
    if (!ok || cpu_enable !== 1'b1 || err !== 1'b1) begin
      nerr++;
      $display("FAIL arst_setup: m_valid=%b en=%b err=%b want 1 1 1", m_valid, cpu_enable, err);
    end
    #1 arst = 1'b1;
    #1;
    nvec++;
    if ({m_valid, ren_ext, busy, cpu_enable, err} !== 5'b0) begin
      nerr++;
      $display("FAIL arst_async: mv/ren/busy/en/err=%b want 00000", {m_valid, ren_ext, busy, cpu_enable, err});
    end
    @(negedge clk);
    arst = 1'b0;
    @(negedge clk);
    wi_a.delete(); wi_d.delete(); wi_c.delete();
    send(hdr(4'd0, 12'd0, 32'h20));
    send(64'h55);
    repeat (2) @(negedge clk);
    nvec++;
    if (wi_a.size() != 1 || wi_a[0] !== 32'h20 || wi_d[0] !== 32'h55 || err !== 1'b0) begin
      nerr++;
      $display("FAIL arst_after: %0d writes %h/%h err=%b want 1 20/55 0", wi_a.size(), wi_a[0], wi_d[0], err);
    end
  endtask

  initial begin
    test_reset();
    test_wr_i();
    test_wr_rd_d();
    test_run_reject();
    test_illegal();
    test_wrap();
    test_arst();
    nvec++;
    if (viol != 0) begin
      nerr++;
      $display("FAIL exclusivity: got %0d violations want 0", viol);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

endmodule
